// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM that sequences the multi-cycle RV64 datapath
// (fetch, decode, execute, memory, writeback) for R-type, ld, sd and beq.
// It also holds the memory wait handshake, a sticky illegal-opcode trap and a
// retired-instruction counter.
// Optional feature: define MULTICYCLE_CTRL_TIMEOUT_EN to add a memory wait
// timeout that parks the FSM in TIMEOUT after TIMEOUT_CYCLES stalled cycles.
module multicycle_control #(
  parameter int          CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic             mem_timeout,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_EXEC_R    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_TRAP      = 4'd10;
  localparam logic [3:0] S_TIMEOUT   = 4'd11;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [3:0]       state_q, state_d;
  logic             is_store_q, is_store_d;
  logic [CNT_W-1:0] instr_retired_q, instr_retired_d;
  logic             retire;
  logic             waiting;

  // The branch decision is made in the datapath (pc_write_cond AND zero);
  // the controller itself never looks at the flag.
  logic unused_zero;
  assign unused_zero = zero;

  // FETCH, MEM_READ and MEM_WRITE are the only states that stall on memory.
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                   (state_q == S_MEM_WRITE);

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] wait_inc;
  logic       wait_expired;

  assign wait_inc     = wait_cnt_q + 8'd1;
  // mem_ready in the limit cycle wins, so expiry needs a stalled cycle.
  assign wait_expired = waiting && !mem_ready && (wait_inc == 8'(TIMEOUT_CYCLES));
`else
  logic       wait_expired;
  logic [7:0] unused_timeout_cfg;

  assign wait_expired       = 1'b0;
  assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
`endif

  // Next-state selection; the ld/sd choice is captured in DECODE so MEM_ADDR
  // does not depend on opcode outside the decode cycle.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        is_store_d = (opcode == OP_SD);
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_LD, OP_SD: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      S_TIMEOUT:   state_d = S_TIMEOUT;
      default:     state_d = S_IDLE;
    endcase
    if (wait_expired) state_d = S_TIMEOUT;
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    retire = (state_q == S_MEM_WB) || (state_q == S_R_WB) ||
             (state_q == S_BRANCH) || ((state_q == S_MEM_WRITE) && mem_ready);
    instr_retired_d = retire ? instr_retired_q + CNT_W'(1) : instr_retired_q;
  end

  // State, store flag and retire counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      is_store_q      <= 1'b0;
      instr_retired_q <= '0;
    end else begin
      state_q         <= state_d;
      is_store_q      <= is_store_d;
      instr_retired_q <= instr_retired_d;
    end
  end

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  // Wait counter restarts whenever the state changes (i.e. on entry to a
  // wait state) and counts stalled cycles while the state holds.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) wait_cnt_d = 8'd0;
    else if (waiting && !mem_ready) wait_cnt_d = wait_inc;
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt_q <= 8'd0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`endif

  // Moore control decode; only ir_write/pc_write look at mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_R_WB:   reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 2'b10;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal       = (state_q == S_TRAP);
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  assign mem_timeout   = (state_q == S_TIMEOUT);
`else
  assign mem_timeout   = 1'b0;
`endif
  assign state_dbg     = state_q;
  assign instr_retired = instr_retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and randomized instruction streams for
// multicycle_control, checked cycle by cycle against a per-instruction model
// that expands each instruction into its expected list of states.
module tb_multicycle_control;

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, pc_source, ir_write, i_or_d;
  logic        mem_read, mem_write, mem_to_reg, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, alu_op;
  logic        illegal, mem_timeout;
  logic [3:0]  state_dbg;
  logic [31:0] instr_retired;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_cnt = 0;

  logic [16:0] ctrl_obs;
  assign ctrl_obs = {pc_write, pc_write_cond, pc_source, ir_write, i_or_d,
                     mem_read, mem_write, mem_to_reg, reg_write,
                     alu_src_a, alu_src_b, alu_op, illegal, mem_timeout};

  multicycle_control #(.CNT_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal), .mem_timeout(mem_timeout),
    .state_dbg(state_dbg), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  // Expected control word for a state, straight from the per-state table.
  function automatic logic [16:0] exp_ctrl(input int st, input bit rdy);
    logic pw, pwc, psrc, irw, iod, mr, mw, m2r, rw, ill, tmo;
    logic [1:0] sa, sb, op;
    {pw, pwc, psrc, irw, iod, mr, mw, m2r, rw, ill, tmo} = '0;
    sa = 2'b00; sb = 2'b00; op = 2'b00;
    case (st)
      1:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      2:  begin sa = 2'b01; sb = 2'b10; end
      3:  begin sa = 2'b10; sb = 2'b10; end
      4:  begin mr = 1; iod = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mw = 1; iod = 1; end
      7:  begin sa = 2'b10; op = 2'b10; end
      8:  rw = 1;
      9:  begin sa = 2'b10; op = 2'b01; pwc = 1; psrc = 1; end
      10: ill = 1;
      11: tmo = 1;
      default: ;
    endcase
    return {pw, pwc, psrc, irw, iod, mr, mw, m2r, rw, sa, sb, op, ill, tmo};
  endfunction

  task automatic check_cycle(input int st, input bit rdy, input string tag);
    vectors++;
    assert ({state_dbg, ctrl_obs} === {4'(st), exp_ctrl(st, rdy)})
      else begin
        miscompares++;
        $error("FAIL %s state/ctrl: observed %h/%h expected %h/%h",
               tag, state_dbg, ctrl_obs, 4'(st), exp_ctrl(st, rdy));
      end
    vectors++;
    assert (instr_retired === model_cnt)
      else begin
        miscompares++;
        $error("FAIL %s instr_retired: observed %0d expected %0d",
               tag, instr_retired, model_cnt);
      end
  endtask

  // One clock cycle: drive mem_ready, check, and credit a retirement that
  // takes effect on the coming rising edge.
  task automatic step(input int st, input bit rdy, input bit retire, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    check_cycle(st, rdy, tag);
    if (retire) model_cnt = model_cnt + 1;
  endtask

  // Release reset on a falling edge; the following cycle is IDLE.
  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 0;
    #1;
    check_cycle(0, 1'b0, "idle_after_reset");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  // Expand one instruction into its expected state sequence and run it.
  // wf/wm are stall cycles in the fetch and memory accesses.
  task automatic run_instr(input logic [6:0] opc, input int wf, input int wm,
                           input bit z, input string tag);
    int  sts[$];
    bit  rdys[$];
    bit  ret[$];
    opcode = opc;
    zero   = z;
    for (int i = 0; i < wf; i++) begin sts.push_back(1); rdys.push_back(0); ret.push_back(0); end
    sts.push_back(1); rdys.push_back(1); ret.push_back(0);
    sts.push_back(2); rdys.push_back(1'($urandom)); ret.push_back(0);
    case (opc)
      7'b0110011: begin
        sts.push_back(7); rdys.push_back(1'($urandom)); ret.push_back(0);
        sts.push_back(8); rdys.push_back(1'($urandom)); ret.push_back(1);
      end
      7'b0000011: begin
        sts.push_back(3); rdys.push_back(1'($urandom)); ret.push_back(0);
        for (int i = 0; i < wm; i++) begin sts.push_back(4); rdys.push_back(0); ret.push_back(0); end
        sts.push_back(4); rdys.push_back(1); ret.push_back(0);
        sts.push_back(5); rdys.push_back(1'($urandom)); ret.push_back(1);
      end
      7'b0100011: begin
        sts.push_back(3); rdys.push_back(1'($urandom)); ret.push_back(0);
        for (int i = 0; i < wm; i++) begin sts.push_back(6); rdys.push_back(0); ret.push_back(0); end
        sts.push_back(6); rdys.push_back(1); ret.push_back(1);
      end
      7'b1100011: begin
        sts.push_back(9); rdys.push_back(1'($urandom)); ret.push_back(1);
      end
      default: begin
        for (int i = 0; i < 20; i++) begin
          sts.push_back(10); rdys.push_back(1'($urandom)); ret.push_back(0);
        end
      end
    endcase
    for (int i = 0; i < sts.size(); i++) step(sts[i], rdys[i], ret[i], tag);
  endtask

  initial begin
    logic [6:0] ops [4];
    ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0100011; ops[3] = 7'b1100011;
    reset = 1'b1; mem_ready = 1'b0; opcode = 7'd0; zero = 1'b0;
    #1;
    check_cycle(0, 1'b0, "reset_state");
    repeat (2) @(negedge clk);
    release_reset();

    // Directed instruction types.
    run_instr(7'b0110011, 0, 0, 1'b0, "rtype");
    run_instr(7'b0000011, 0, 2, 1'b0, "ld_wait2");
    run_instr(7'b1100011, 0, 0, 1'b1, "beq_z1");
    run_instr(7'b1100011, 0, 0, 1'b0, "beq_z0");
    run_instr(7'b0100011, 1, 1, 1'b0, "sd_wait");

    // Randomized stream; stalls stay below the timeout limit.
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(3, 0)], int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)), 1'($urandom), "random");

    // Asynchronous reset in the middle of a stalled fetch.
    step(1, 1'b0, 1'b0, "fetch_stall_a");
    step(1, 1'b0, 1'b0, "fetch_stall_b");
    #2;
    reset = 1'b1;
    #1;
    model_cnt = 0;
    check_cycle(0, 1'b0, "async_reset_midfetch");
    repeat (2) @(negedge clk);
    release_reset();
    run_instr(7'b0110011, 0, 0, 1'b0, "rtype_after_reset");

    // Illegal opcode: trap held for 20 cycles with the counter frozen.
    run_instr(7'b0010011, 0, 0, 1'b0, "trap");
    pulse_reset();
    run_instr(7'b0000011, 0, 0, 1'b0, "ld_after_trap");

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    // Fetch stalled for the full limit parks in TIMEOUT.
    pulse_reset();
    for (int i = 0; i < TO; i++) step(1, 1'b0, 1'b0, "fetch_to_timeout");
    for (int i = 0; i < 3; i++)  step(11, 1'($urandom), 1'b0, "timeout_hold");
    // Ready on the last allowed wait cycle proceeds normally.
    pulse_reset();
    run_instr(7'b0110011, TO - 1, 0, 1'b0, "ready_at_limit");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
